// File: rtl/types_pkg.sv
// Shared TIS-100 node types.
//   word_t      : 11-bit node data word
//   src_t       : read source selected by the core (UP..ACC)
//   direction_t : physical/virtual port direction, literals prefixed DIR_
//   rxstate_t   : read-port FSM states
//   src_to_dir  : maps a src_t onto its direction_t
package types_pkg;

    localparam int unsigned WORD_SIZE = 11;
    localparam int unsigned NPORTS    = 4;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [2:0] {
        UP    = 3'd0,
        DOWN  = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        ANY   = 3'd4,
        LAST  = 3'd5,
        NIL   = 3'd6,
        ACC   = 3'd7
    } src_t;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_ANY   = 3'd4,
        DIR_LAST  = 3'd5
    } direction_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_DONE = 2'd2
    } rxstate_t;

    // NIL and ACC have no port; they fall back to DIR_UP and are never used to select one.
    function automatic direction_t src_to_dir(input src_t src);
        direction_t d;
        case (src)
            UP:      d = DIR_UP;
            DOWN:    d = DIR_DOWN;
            LEFT:    d = DIR_LEFT;
            RIGHT:   d = DIR_RIGHT;
            ANY:     d = DIR_ANY;
            LAST:    d = DIR_LAST;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tis_any_arb.sv
// Fixed-priority arbiter for ANY reads: LEFT > RIGHT > UP > DOWN.
//   valid : per-direction valid, indexed by direction_t
//   grant : one-hot grant (all zero when nothing is valid)
//   dir   : direction of the granted port (DIR_LEFT when nothing is valid)
module tis_any_arb
    import types_pkg::*;
(
    input  logic [NPORTS-1:0] valid,
    output logic [NPORTS-1:0] grant,
    output direction_t        dir
);

    always_comb begin
        grant = '0;
        dir   = DIR_LEFT;
        if (valid[DIR_LEFT]) begin
            grant[DIR_LEFT] = 1'b1;
            dir             = DIR_LEFT;
        end else if (valid[DIR_RIGHT]) begin
            grant[DIR_RIGHT] = 1'b1;
            dir              = DIR_RIGHT;
        end else if (valid[DIR_UP]) begin
            grant[DIR_UP] = 1'b1;
            dir           = DIR_UP;
        end else if (valid[DIR_DOWN]) begin
            grant[DIR_DOWN] = 1'b1;
            dir             = DIR_DOWN;
        end
    end

endmodule

// File: rtl/tis_port_rx.sv
// Read side of the TIS-100 inter-node blocking port.
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   rd_req    : read request from the core, sampled in IDLE with rd_src
//   busy      : high while a read is in progress (WAIT/DONE)
//   rd_done   : one-cycle completion pulse; rd_data valid this cycle
//   rd_data   : word read, held until the next completion
//   rd_err    : pulses with rd_done for an ACC source; data is zero
//   in_valid  : neighbour word available, indexed by direction_t
//   in_data   : neighbour words, same index
//   in_ready  : one-hot ack, only in WAIT
module tis_port_rx
    import types_pkg::*;
(
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     rd_req,
    input  src_t                     rd_src,
    output logic                     busy,
    output logic                     rd_done,
    output word_t                    rd_data,
    output logic                     rd_err,
    input  logic [NPORTS-1:0]        in_valid,
    input  word_t [NPORTS-1:0]       in_data,
    output logic [NPORTS-1:0]        in_ready
);

    rxstate_t          state, state_nx;
    src_t              cur_src;
    logic              last_vld;
    direction_t        last_dir;
    logic              err_q;

    logic [NPORTS-1:0] any_grant;
    direction_t        any_dir;
    direction_t        tgt_dir;
    logic [1:0]        tgt_idx;
    logic [NPORTS-1:0] tgt_sel;
    logic              tgt_valid;
    logic              direct;

    tis_any_arb u_any_arb (
        .valid (in_valid),
        .grant (any_grant),
        .dir   (any_dir)
    );

    // Target selection; in_ready is built only from state, cur_src, last_dir and in_valid.
    always_comb begin
        tgt_dir = src_to_dir(cur_src);
        case (cur_src)
            ANY:     tgt_dir = any_dir;
            LAST:    tgt_dir = last_dir;
            default: ;
        endcase
        tgt_idx = tgt_dir[1:0];
        tgt_sel = '0;
        if (cur_src == ANY) begin
            tgt_sel = any_grant;
        end else begin
            tgt_sel[tgt_idx] = 1'b1;
        end
        tgt_valid = |(tgt_sel & in_valid);
        in_ready  = (state == RX_WAIT && tgt_valid) ? tgt_sel : '0;
    end

    // Requests that complete without touching a neighbour.
    always_comb begin
        direct = (rd_src == NIL) || (rd_src == ACC) || (rd_src == LAST && !last_vld);
    end

    always_comb begin
        state_nx = state;
        case (state)
            RX_IDLE: if (rd_req) state_nx = direct ? RX_DONE : RX_WAIT;
            RX_WAIT: if (tgt_valid) state_nx = RX_DONE;
            RX_DONE: state_nx = RX_IDLE;
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_src  <= UP;
            err_q    <= 1'b0;
            rd_data  <= '0;
            last_vld <= 1'b0;
            last_dir <= DIR_UP;
        end else begin
            if (state == RX_IDLE && rd_req) begin
                cur_src <= rd_src;
                err_q   <= (rd_src == ACC);
                if (direct) begin
                    rd_data <= '0;
                end
            end
            if (state == RX_WAIT && tgt_valid) begin
                rd_data <= in_data[tgt_idx];
                if (cur_src == ANY) begin
                    last_vld <= 1'b1;
                    last_dir <= tgt_dir;
                end
            end
        end
    end

    assign busy    = (state != RX_IDLE);
    assign rd_done = (state == RX_DONE);
    assign rd_err  = (state == RX_DONE) && err_q;

endmodule
